pw_pattern_matcher: RTL and testbench

Front-end byte-stream pattern matcher that runs on `fe_clk`. It compares the most recent captured bytes against a masked pattern that is snapshotted at arm time. On a hit it emits a fixed-width match pulse, sized so that the CDC pulse transfer into the trigger-delay stage sees one clean rising edge per event. It sits directly upstream of the trigger-delay/width generator and drives that block's match input.

---
 rtl/pw_pattern_matcher.sv | 168 ++++++++++++++++
 tb/tb_pw_pattern_matcher.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pw_pattern_matcher.sv
// Byte-stream pattern matcher: compares the newest captured bytes against a masked,
// arm-time snapshot and emits a fixed-width, gap-separated match pulse for the trigger stage.
`timescale 1ns/1ps
module pw_pattern_matcher #(
    parameter int pBYTES     = 8,
    parameter int pHOLD      = 4,
    parameter int pGAP       = 4,
    parameter int pCNT_WIDTH = 16
) (
    input  logic                         fe_clk,
    input  logic                         resetn,
    input  logic                         I_arm,
    input  logic                         I_disarm,
    input  logic                         I_continuous,
    input  logic [8*pBYTES-1:0]          I_pattern,
    input  logic [8*pBYTES-1:0]          I_mask,
    input  logic [$clog2(pBYTES+1)-1:0]  I_pattern_bytes,
    input  logic [7:0]                   I_data,
    input  logic                         I_data_valid,
    output logic                         O_match,
    output logic                         O_armed,
    output logic [pCNT_WIDTH-1:0]        O_match_count
);

    localparam int LW   = $clog2(pBYTES + 1);
    localparam int TMAX = (pHOLD > pGAP) ? pHOLD : pGAP;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {IDLE, ARMED, HOLD, GAP} state_t;

    state_t              state, state_next;
    logic [7:0]          window  [pBYTES];
    logic [7:0]          shifted [pBYTES];
    logic [8*pBYTES-1:0] snap_pattern, snap_mask;
    logic [LW-1:0]       snap_len, eff_len, fill, fill_inc;
    logic                snap_cont;
    logic [TW-1:0]       timer, timer_next;
    logic                hit, arm_go, enter_armed, enter_hold;

    assign arm_go  = I_arm && !I_disarm;
    assign O_match = (state == HOLD);
    assign O_armed = (state == ARMED);

    // The hit is judged on the window as it will look after this edge's shift.
    always_comb begin
        shifted[0] = I_data;
        for (int i = 1; i < pBYTES; i++) begin
            shifted[i] = window[i-1];
        end
    end

    always_comb begin
        if (snap_len == '0) begin
            eff_len = LW'(1);
        end else if (snap_len > LW'(pBYTES)) begin
            eff_len = LW'(pBYTES);
        end else begin
            eff_len = snap_len;
        end
        fill_inc = (fill == LW'(pBYTES)) ? fill : fill + LW'(1);
        hit = I_data_valid && (state == ARMED) && (fill_inc >= eff_len);
        for (int i = 0; i < pBYTES; i++) begin
            if ((LW'(i) < eff_len) &&
                (((shifted[i] ^ snap_pattern[8*i +: 8]) & snap_mask[8*i +: 8]) != 8'h00)) begin
                hit = 1'b0;
            end
        end
    end

    // GAP holds pGAP-1 cycles; the ARMED cycle that collects the first fresh byte
    // is the last forced-low cycle, so back-to-back pulses are pHOLD+pGAP apart.
    always_comb begin
        state_next = state;
        timer_next = timer;
        if (I_disarm) begin
            state_next = IDLE;
        end else if (I_arm) begin
            state_next = ARMED;
        end else begin
            case (state)
                IDLE: state_next = IDLE;
                ARMED: begin
                    if (hit) begin
                        state_next = HOLD;
                        timer_next = '0;
                    end
                end
                HOLD: begin
                    if (timer == TW'(pHOLD - 1)) begin
                        state_next = GAP;
                        timer_next = '0;
                    end else begin
                        timer_next = timer + TW'(1);
                    end
                end
                GAP: begin
                    if (timer == TW'(pGAP - 2)) begin
                        state_next = snap_cont ? ARMED : IDLE;
                    end else begin
                        timer_next = timer + TW'(1);
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign enter_armed = (state_next == ARMED) && ((state != ARMED) || arm_go);
    assign enter_hold  = (state_next == HOLD) && (state != HOLD);

    always_ff @(posedge fe_clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_next;
            timer <= timer_next;
        end
    end

    always_ff @(posedge fe_clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < pBYTES; i++) begin
                window[i] <= 8'h00;
            end
        end else if (I_data_valid) begin
            for (int i = 0; i < pBYTES; i++) begin
                window[i] <= shifted[i];
            end
        end
    end

    always_ff @(posedge fe_clk or negedge resetn) begin
        if (!resetn) begin
            snap_pattern <= '0;
            snap_mask    <= '0;
            snap_len     <= '0;
            snap_cont    <= 1'b0;
        end else if (arm_go) begin
            snap_pattern <= I_pattern;
            snap_mask    <= I_mask;
            snap_len     <= I_pattern_bytes;
            snap_cont    <= I_continuous;
        end
    end

    // Only bytes seen while ARMED count, so a re-match always needs N fresh bytes.
    always_ff @(posedge fe_clk or negedge resetn) begin
        if (!resetn) begin
            fill <= '0;
        end else if (enter_armed) begin
            fill <= '0;
        end else if ((state == ARMED) && I_data_valid) begin
            fill <= fill_inc;
        end
    end

    always_ff @(posedge fe_clk or negedge resetn) begin
        if (!resetn) begin
            O_match_count <= '0;
        end else if (arm_go) begin
            O_match_count <= '0;
        end else if (enter_hold && (O_match_count != '1)) begin
            O_match_count <= O_match_count + pCNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_pw_pattern_matcher.sv
// Self-checking bench for pw_pattern_matcher: expected pulse edges are queued as stimulus
// is driven and compared against edges recorded by a monitor on the match output.
`timescale 1ns/1ps
module tb_pw_pattern_matcher;

    logic        fe_clk = 1'b0;
    logic        resetn;
    logic        arm, disarm, continuous;
    logic [63:0] pattern, mask;
    logic [3:0]  pattern_bytes;
    logic [7:0]  data;
    logic        data_valid;
    logic        match, armed;
    logic [15:0] match_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic prev_match = 1'b0;
    int rise_q[$], fall_q[$], exp_rise_q[$], exp_fall_q[$];

    pw_pattern_matcher #(
        .pBYTES(8), .pHOLD(4), .pGAP(4), .pCNT_WIDTH(16)
    ) dut (
        .fe_clk          (fe_clk),
        .resetn          (resetn),
        .I_arm           (arm),
        .I_disarm        (disarm),
        .I_continuous    (continuous),
        .I_pattern       (pattern),
        .I_mask          (mask),
        .I_pattern_bytes (pattern_bytes),
        .I_data          (data),
        .I_data_valid    (data_valid),
        .O_match         (match),
        .O_armed         (armed),
        .O_match_count   (match_count)
    );

    always #5 fe_clk = ~fe_clk;

    always @(posedge fe_clk) cyc <= cyc + 1;

    // Records the edge index at which the match output was first seen high / low.
    always @(negedge fe_clk) begin
        if (match && !prev_match) rise_q.push_back(cyc);
        if (!match && prev_match) fall_q.push_back(cyc);
        prev_match <= match;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic feed(input logic v, input logic [7:0] d);
        data_valid = v;
        data = d;
        @(posedge fe_clk);
        #1;
        data_valid = 1'b0;
        arm = 1'b0;
        disarm = 1'b0;
    endtask

    // Arms, then scrambles the configuration inputs so only the snapshot can matter.
    task automatic arm_with(input logic [63:0] pat, input logic [63:0] msk,
                            input logic [3:0] len, input logic cont);
        pattern = pat;
        mask = msk;
        pattern_bytes = len;
        continuous = cont;
        arm = 1'b1;
        feed(1'b0, 8'h00);
        pattern = ~pat;
        mask = 64'h0;
        pattern_bytes = 4'd1;
        continuous = ~cont;
    endtask

    task automatic expect_pulse(input int width);
        exp_rise_q.push_back(cyc);
        exp_fall_q.push_back(cyc + width);
    endtask

    task automatic clear_queues();
        rise_q.delete();
        fall_q.delete();
        exp_rise_q.delete();
        exp_fall_q.delete();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge fe_clk);
        #1;
        checks++; if (match !== 1'b0) begin errors++; $display("[TB] FAIL reset_match: got %0b expected 0", match); end
        checks++; if (armed !== 1'b0) begin errors++; $display("[TB] FAIL reset_armed: got %0b expected 0", armed); end
        checks++; if (match_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", match_count); end
        resetn = 1'b1;
        feed(1'b1, 8'h12);
        feed(1'b0, 8'h00);
        checks++; if (armed !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_armed: got %0b expected 0", armed); end
        checks++; if (match !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_match: got %0b expected 0", match); end
    endtask

    task automatic test_single_hit();
        int e_v, o_v;
        clear_queues();
        arm_with(64'h0000_0000_0000_A53C, 64'h0000_0000_0000_FFFF, 4'd2, 1'b0);
        checks++; if (armed !== 1'b1) begin errors++; $display("[TB] FAIL single_armed: got %0b expected 1", armed); end
        feed(1'b1, 8'h00);
        feed(1'b1, 8'hA5);
        feed(1'b1, 8'h3C);
        expect_pulse(4);
        repeat (10) feed(1'b0, 8'h00);
        checks++; if (match_count !== 16'd1) begin errors++; $display("[TB] FAIL single_count: got %0d expected 1", match_count); end
        checks++; if (armed !== 1'b0) begin errors++; $display("[TB] FAIL single_idle: got %0b expected 0", armed); end
        feed(1'b1, 8'hA5);
        feed(1'b1, 8'h3C);
        repeat (8) feed(1'b0, 8'h00);
        checks++; if (rise_q.size() != exp_rise_q.size()) begin errors++; $display("[TB] FAIL single_pulses: got %0d expected %0d", rise_q.size(), exp_rise_q.size()); end
        while (exp_rise_q.size() > 0 && rise_q.size() > 0) begin
            e_v = exp_rise_q.pop_front(); o_v = rise_q.pop_front();
            checks++; if (o_v != e_v) begin errors++; $display("[TB] FAIL single_rise: got %0d expected %0d", o_v, e_v); end
        end
        while (exp_fall_q.size() > 0 && fall_q.size() > 0) begin
            e_v = exp_fall_q.pop_front(); o_v = fall_q.pop_front();
            checks++; if (o_v != e_v) begin errors++; $display("[TB] FAIL single_fall: got %0d expected %0d", o_v, e_v); end
        end
    endtask

    task automatic test_mask_stale();
        int e_v, o_v;
        clear_queues();
        arm_with(64'h30, 64'hF0, 4'd1, 1'b0);
        feed(1'b1, 8'h4F);
        feed(1'b1, 8'h3F);
        expect_pulse(4);
        feed(1'b1, 8'h3F);
        feed(1'b1, 8'h3F);
        repeat (8) feed(1'b0, 8'h00);
        checks++; if (match_count !== 16'd1) begin errors++; $display("[TB] FAIL mask_count: got %0d expected 1", match_count); end
        arm_with(64'h3F3F3F, 64'hFFFFFF, 4'd3, 1'b0);
        checks++; if (match_count !== 16'd0) begin errors++; $display("[TB] FAIL rearm_count_clear: got %0d expected 0", match_count); end
        feed(1'b1, 8'h3F);
        feed(1'b1, 8'h3F);
        checks++; if (match !== 1'b0) begin errors++; $display("[TB] FAIL stale_fill: got %0b expected 0", match); end
        feed(1'b1, 8'h3F);
        expect_pulse(4);
        checks++; if (match !== 1'b1) begin errors++; $display("[TB] FAIL third_byte_hit: got %0b expected 1", match); end
        repeat (8) feed(1'b0, 8'h00);
        checks++; if (rise_q.size() != exp_rise_q.size()) begin errors++; $display("[TB] FAIL mask_pulses: got %0d expected %0d", rise_q.size(), exp_rise_q.size()); end
        while (exp_rise_q.size() > 0 && rise_q.size() > 0) begin
            e_v = exp_rise_q.pop_front(); o_v = rise_q.pop_front();
            checks++; if (o_v != e_v) begin errors++; $display("[TB] FAIL mask_rise: got %0d expected %0d", o_v, e_v); end
        end
        while (exp_fall_q.size() > 0 && fall_q.size() > 0) begin
            e_v = exp_fall_q.pop_front(); o_v = fall_q.pop_front();
            checks++; if (o_v != e_v) begin errors++; $display("[TB] FAIL mask_fall: got %0d expected %0d", o_v, e_v); end
        end
    endtask

    task automatic test_back_to_back();
        int e_v, o_v, seen;
        clear_queues();
        arm_with(64'h55, 64'hFF, 4'd1, 1'b1);
        for (int i = 0; i < 30; i++) begin
            feed(1'b1, 8'h55);
            if (i % 8 == 0) expect_pulse(4);
        end
        checks++; if (match_count !== 16'd4) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected 4", match_count); end
        seen = rise_q.size();
        checks++; if (int'(match_count) != seen) begin errors++; $display("[TB] FAIL b2b_count_vs_seen: got %0d expected %0d", match_count, seen); end
        disarm = 1'b1;
        feed(1'b0, 8'h00);
        repeat (4) feed(1'b0, 8'h00);
        checks++; if (rise_q.size() != exp_rise_q.size()) begin errors++; $display("[TB] FAIL b2b_pulses: got %0d expected %0d", rise_q.size(), exp_rise_q.size()); end
        while (exp_rise_q.size() > 0 && rise_q.size() > 0) begin
            e_v = exp_rise_q.pop_front(); o_v = rise_q.pop_front();
            checks++; if (o_v != e_v) begin errors++; $display("[TB] FAIL b2b_rise: got %0d expected %0d", o_v, e_v); end
        end
        while (exp_fall_q.size() > 0 && fall_q.size() > 0) begin
            e_v = exp_fall_q.pop_front(); o_v = fall_q.pop_front();
            checks++; if (o_v != e_v) begin errors++; $display("[TB] FAIL b2b_fall: got %0d expected %0d", o_v, e_v); end
        end
    endtask

    task automatic test_disarm();
        int e_v, o_v;
        clear_queues();
        arm_with(64'h77, 64'hFF, 4'd1, 1'b1);
        feed(1'b1, 8'h77);
        expect_pulse(2);
        feed(1'b0, 8'h00);
        checks++; if (match !== 1'b1) begin errors++; $display("[TB] FAIL disarm_hold2: got %0b expected 1", match); end
        disarm = 1'b1;
        feed(1'b0, 8'h00);
        checks++; if (match !== 1'b0) begin errors++; $display("[TB] FAIL disarm_match: got %0b expected 0", match); end
        checks++; if (armed !== 1'b0) begin errors++; $display("[TB] FAIL disarm_armed: got %0b expected 0", armed); end
        repeat (3) feed(1'b1, 8'h77);
        checks++; if (armed !== 1'b0) begin errors++; $display("[TB] FAIL disarm_stays_idle: got %0b expected 0", armed); end
        arm = 1'b1;
        disarm = 1'b1;
        feed(1'b0, 8'h00);
        checks++; if (armed !== 1'b0) begin errors++; $display("[TB] FAIL arm_disarm_priority: got %0b expected 0", armed); end
        repeat (4) feed(1'b1, 8'h77);
        repeat (2) feed(1'b0, 8'h00);
        checks++; if (rise_q.size() != exp_rise_q.size()) begin errors++; $display("[TB] FAIL disarm_pulses: got %0d expected %0d", rise_q.size(), exp_rise_q.size()); end
        while (exp_rise_q.size() > 0 && rise_q.size() > 0) begin
            e_v = exp_rise_q.pop_front(); o_v = rise_q.pop_front();
            checks++; if (o_v != e_v) begin errors++; $display("[TB] FAIL disarm_rise: got %0d expected %0d", o_v, e_v); end
        end
        while (exp_fall_q.size() > 0 && fall_q.size() > 0) begin
            e_v = exp_fall_q.pop_front(); o_v = fall_q.pop_front();
            checks++; if (o_v != e_v) begin errors++; $display("[TB] FAIL disarm_fall: got %0d expected %0d", o_v, e_v); end
        end
    endtask

    task automatic test_length_clamp();
        int e_v, o_v;
        clear_queues();
        arm_with(64'hEE9A, 64'hFFFF, 4'd0, 1'b0);
        feed(1'b1, 8'h9A);
        expect_pulse(4);
        checks++; if (match !== 1'b1) begin errors++; $display("[TB] FAIL len0_hit: got %0b expected 1", match); end
        repeat (8) feed(1'b0, 8'h00);
        arm_with(64'hC3C3_C3C3_C3C3_C3C3, 64'hFFFF_FFFF_FFFF_FFFF, 4'd15, 1'b0);
        for (int i = 0; i < 8; i++) begin
            feed(1'b1, 8'hC3);
            if (i < 7) begin
                checks++; if (match !== 1'b0) begin errors++; $display("[TB] FAIL clamp_early_%0d: got %0b expected 0", i, match); end
            end else begin
                expect_pulse(4);
            end
        end
        checks++; if (match !== 1'b1) begin errors++; $display("[TB] FAIL clamp_8th: got %0b expected 1", match); end
        repeat (8) feed(1'b0, 8'h00);
        checks++; if (rise_q.size() != exp_rise_q.size()) begin errors++; $display("[TB] FAIL clamp_pulses: got %0d expected %0d", rise_q.size(), exp_rise_q.size()); end
        while (exp_rise_q.size() > 0 && rise_q.size() > 0) begin
            e_v = exp_rise_q.pop_front(); o_v = rise_q.pop_front();
            checks++; if (o_v != e_v) begin errors++; $display("[TB] FAIL clamp_rise: got %0d expected %0d", o_v, e_v); end
        end
        while (exp_fall_q.size() > 0 && fall_q.size() > 0) begin
            e_v = exp_fall_q.pop_front(); o_v = fall_q.pop_front();
            checks++; if (o_v != e_v) begin errors++; $display("[TB] FAIL clamp_fall: got %0d expected %0d", o_v, e_v); end
        end
    endtask

    task automatic test_async_reset();
        int e_v, o_v;
        clear_queues();
        arm_with(64'h66, 64'hFF, 4'd1, 1'b1);
        feed(1'b1, 8'h66);
        expect_pulse(1);
        feed(1'b0, 8'h00);
        #2;
        resetn = 1'b0;
        #1;
        checks++; if (match !== 1'b0) begin errors++; $display("[TB] FAIL async_match: got %0b expected 0", match); end
        checks++; if (armed !== 1'b0) begin errors++; $display("[TB] FAIL async_armed: got %0b expected 0", armed); end
        checks++; if (match_count !== 16'd0) begin errors++; $display("[TB] FAIL async_count: got %0d expected 0", match_count); end
        @(posedge fe_clk);
        #1;
        resetn = 1'b1;
        repeat (4) feed(1'b1, 8'h66);
        checks++; if (armed !== 1'b0) begin errors++; $display("[TB] FAIL async_idle: got %0b expected 0", armed); end
        arm_with(64'h66, 64'hFF, 4'd1, 1'b0);
        feed(1'b1, 8'h66);
        expect_pulse(4);
        repeat (8) feed(1'b0, 8'h00);
        checks++; if (rise_q.size() != exp_rise_q.size()) begin errors++; $display("[TB] FAIL async_pulses: got %0d expected %0d", rise_q.size(), exp_rise_q.size()); end
        while (exp_rise_q.size() > 0 && rise_q.size() > 0) begin
            e_v = exp_rise_q.pop_front(); o_v = rise_q.pop_front();
            checks++; if (o_v != e_v) begin errors++; $display("[TB] FAIL async_rise: got %0d expected %0d", o_v, e_v); end
        end
        while (exp_fall_q.size() > 0 && fall_q.size() > 0) begin
            e_v = exp_fall_q.pop_front(); o_v = fall_q.pop_front();
            checks++; if (o_v != e_v) begin errors++; $display("[TB] FAIL async_fall: got %0d expected %0d", o_v, e_v); end
        end
    endtask

    initial begin
        resetn = 1'b0;
        arm = 1'b0;
        disarm = 1'b0;
        continuous = 1'b0;
        pattern = 64'h0;
        mask = 64'h0;
        pattern_bytes = 4'd0;
        data = 8'h00;
        data_valid = 1'b0;
        $display("[TB] starting pw_pattern_matcher bench");
        test_reset();
        test_single_hit();
        test_mask_stale();
        test_back_to_back();
        test_disarm();
        test_length_clamp();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
